// File: rtl/oled_pkg.sv
// Shared definitions for the 96x64 OLED score path: sequencer states,
// RGB565 colour constants and panel geometry.
package oled_pkg;

  typedef enum logic [1:0] {
    PLAY = 2'd0,
    SHOW = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [15:0] WHITE    = 16'hFFFF;
  localparam logic [15:0] NAVYBLUE = 16'h0010;

  localparam int OLED_WIDTH  = 96;
  localparam int OLED_HEIGHT = 64;

endpackage

// File: rtl/bcd_score_counter.sv
// Saturating score counter kept in binary and BCD side by side so the
// score renderer never has to divide.
module bcd_score_counter #(
  parameter int MAX_SCORE = 30
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       inc,
  input  logic       clr,
  output logic [4:0] score,
  output logic [1:0] tens,
  output logic [3:0] ones
);

  localparam logic [4:0] SCORE_MAX = 5'(MAX_SCORE);

  logic [4:0] score_reg;
  logic [1:0] tens_reg;
  logic [3:0] ones_reg;

  always_ff @(posedge clock) begin
    if (reset || clr) begin
      score_reg <= '0;
      tens_reg  <= '0;
      ones_reg  <= '0;
    end else if (inc && (score_reg != SCORE_MAX)) begin
      score_reg <= score_reg + 5'd1;
      if (ones_reg == 4'd9) begin
        ones_reg <= '0;
        tens_reg <= tens_reg + 2'd1;
      end else begin
        ones_reg <= ones_reg + 4'd1;
      end
    end
  end

  assign score = score_reg;
  assign tens  = tens_reg;
  assign ones  = ones_reg;

endmodule

// File: rtl/score_screen_ctrl.sv
// End-of-game screen sequencer: owns the score counter, the PLAY/SHOW/HOLD
// flow and the frame-aligned switch between game and score pixels.
module score_screen_ctrl
  import oled_pkg::*;
#(
  parameter int MAX_SCORE   = 30,
  parameter int SHOW_FRAMES = 180
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        point,
  input  logic        game_over,
  input  logic        restart,
  input  logic        frame_begin,
  input  logic [15:0] game_oled_data,
  input  logic [15:0] score_oled_data,
  output logic [4:0]  score,
  output logic [1:0]  tens,
  output logic [3:0]  ones,
  output logic        show_score,
  output logic        busy,
  output logic [15:0] oled_data
);

  localparam int FW = $clog2(SHOW_FRAMES + 1);
  localparam logic [FW-1:0] FRAMES_DONE = FW'(SHOW_FRAMES);

  state_t        state_reg, state_next;
  logic [FW-1:0] frame_cnt_reg, frame_cnt_next;
  logic          disp_sel_reg;
  logic [15:0]   oled_data_reg;
  logic          score_inc;

  assign score_inc = point && (state_reg == PLAY) && !restart;

  bcd_score_counter #(
    .MAX_SCORE(MAX_SCORE)
  ) u_counter (
    .clock(clock),
    .reset(reset),
    .inc  (score_inc),
    .clr  (restart),
    .score(score),
    .tens (tens),
    .ones (ones)
  );

  always_comb begin
    state_next     = state_reg;
    frame_cnt_next = frame_cnt_reg;
    case (state_reg)
      PLAY: begin
        if (game_over) begin
          state_next     = SHOW;
          frame_cnt_next = '0;
        end
      end
      SHOW: begin
        // The pulse that reaches the frame target also leaves SHOW.
        if (frame_begin && (frame_cnt_reg != FRAMES_DONE)) begin
          frame_cnt_next = frame_cnt_reg + 1'b1;
          if (frame_cnt_next == FRAMES_DONE) state_next = HOLD;
        end
      end
      HOLD:    state_next = HOLD;
      default: state_next = PLAY;
    endcase
    if (restart) begin
      state_next     = PLAY;
      frame_cnt_next = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= PLAY;
      frame_cnt_reg <= '0;
      disp_sel_reg  <= 1'b0;
      oled_data_reg <= 16'h0000;
    end else begin
      state_reg     <= state_next;
      frame_cnt_reg <= frame_cnt_next;
      // Source switches only at frame start so the panel never tears.
      if (frame_begin) disp_sel_reg <= (state_next != PLAY);
      oled_data_reg <= disp_sel_reg ? score_oled_data : game_oled_data;
    end
  end

  assign show_score = disp_sel_reg;
  assign busy       = (state_reg == SHOW);
  assign oled_data  = oled_data_reg;

endmodule

// File: tb/tb_score_screen_ctrl.sv
// Directed and randomized checks of score_screen_ctrl against a
// behavioural model of the score / end-screen rules.
module tb_score_screen_ctrl;

  localparam int MAX_SCORE   = 30;
  localparam int SHOW_FRAMES = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        point, game_over, restart, frame_begin;
  logic [15:0] game_oled_data, score_oled_data;
  logic [4:0]  score;
  logic [1:0]  tens;
  logic [3:0]  ones;
  logic        show_score, busy;
  logic [15:0] oled_data;

  int n_vec  = 0;
  int n_miss = 0;

  // Model: game is over or not, and how many frames the score has been shown.
  int          m_score   = 0;
  bit          m_over    = 0;
  int          m_frames  = 0;
  bit          m_disp    = 0;
  logic [15:0] m_oled    = 16'h0000;

  always #5 clock = ~clock;

  score_screen_ctrl #(
    .MAX_SCORE  (MAX_SCORE),
    .SHOW_FRAMES(SHOW_FRAMES)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .point          (point),
    .game_over      (game_over),
    .restart        (restart),
    .frame_begin    (frame_begin),
    .game_oled_data (game_oled_data),
    .score_oled_data(score_oled_data),
    .score          (score),
    .tens           (tens),
    .ones           (ones),
    .show_score     (show_score),
    .busy           (busy),
    .oled_data      (oled_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic cyc(input bit p, input bit g, input bit r, input bit fb, input bit rs);
    logic [15:0] gpx, spx;
    gpx = 16'($urandom);
    spx = 16'($urandom);
    point = p; game_over = g; restart = r; frame_begin = fb; reset = rs;
    game_oled_data = gpx; score_oled_data = spx;
    @(posedge clock);
    if (rs) begin
      m_score = 0; m_over = 0; m_frames = 0; m_disp = 0; m_oled = 16'h0000;
    end else begin
      m_oled = m_disp ? spx : gpx;
      if (r) begin
        m_score = 0; m_over = 0; m_frames = 0;
      end else if (!m_over) begin
        if (p && m_score < MAX_SCORE) m_score++;
        if (g) begin m_over = 1; m_frames = 0; end
      end else if (fb && m_frames < SHOW_FRAMES) begin
        m_frames++;
      end
      if (fb) m_disp = m_over;
    end
    #1;
    chk("score",      32'(score),      32'(m_score));
    chk("tens",       32'(tens),       32'(m_score / 10));
    chk("ones",       32'(ones),       32'(m_score % 10));
    chk("show_score", 32'(show_score), 32'(m_disp));
    chk("busy",       32'(busy),       32'(m_over && m_frames < SHOW_FRAMES));
    chk("oled_data",  32'(oled_data),  32'(m_oled));
    $display("cyc p=%0b g=%0b r=%0b fb=%0b rst=%0b -> score=%0d bcd=%0d%0d show=%0b busy=%0b oled=%04h",
             p, g, r, fb, rs, score, tens, ones, show_score, busy, oled_data);
  endtask

  initial begin
    point = 0; game_over = 0; restart = 0; frame_begin = 0; reset = 1;
    game_oled_data = '0; score_oled_data = '0;

    // Reset state.
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);

    // Twelve points in PLAY, with a frame start in between (stays on game).
    repeat (6) cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    repeat (6) cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);

    // Saturation: 35 points from zero.
    cyc(0, 0, 1, 0, 0);
    repeat (35) cyc(1, 0, 0, 0, 0);

    // point and game_over together at score 5, then the SHOW/HOLD sequence.
    cyc(0, 0, 1, 0, 0);
    repeat (5) cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 0, 0);
    for (int f = 0; f < SHOW_FRAMES; f++) begin
      cyc(0, 0, 0, 1, 0);
      cyc(1, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
    end
    repeat (3) cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);

    // restart wins over game_over and point.
    cyc(1, 1, 1, 0, 0);
    cyc(0, 0, 0, 1, 0);

    // Reset during SHOW at score 17.
    repeat (17) cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);

    // Restart coinciding with a frame start while the score is shown.
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 1, 1, 0);
    cyc(0, 0, 0, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 2) == 0,
          $urandom_range(0, 19) == 0,
          $urandom_range(0, 59) == 0,
          $urandom_range(0, 7) == 0,
          $urandom_range(0, 199) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
